// File: rtl/pipe_stage_skid_pkg.sv
// Shared types for the inter-stage skid register: occupancy encoding and
// default widths used by stages that instantiate pipe_stage_skid.
package pipe_stage_skid_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_occ_e;

  localparam int DEF_DATA_W = 64;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_CTRL_W = 8;
  localparam int DEF_CNT_W  = 16;

  // Number of valid entries held in a given occupancy state.
  function automatic logic [1:0] occ_count(input pipe_occ_e occ);
    case (occ)
      ONE:     occ_count = 2'd1;
      TWO:     occ_count = 2'd2;
      default: occ_count = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating event counter: adds 0..2 per cycle, sticks at all-ones,
// and a synchronous clear overrides any increment in the same cycle.
module sat_counter
  import pipe_stage_skid_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W:0] sum;

  // One extra bit catches the carry so the add saturates instead of wrapping.
  always_comb begin
    sum = {1'b0, cnt} + {{(CNT_W-1){1'b0}}, inc};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (sum[CNT_W]) begin
      cnt <= '1;
    end else begin
      cnt <= sum[CNT_W-1:0];
    end
  end

endmodule

// File: rtl/pipe_stage_skid.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid
// entry, synchronous flush and saturating stall/kill counters.
module pipe_stage_skid
  import pipe_stage_skid_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CTRL_W = DEF_CTRL_W,
  parameter int SKID   = 1,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [ADDR_W-1:0] in_dst,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [ADDR_W-1:0] out_dst,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  kill_cnt
);

  pipe_occ_e         occ;
  logic              ready_q;
  logic [CTRL_W-1:0] main_ctrl;
  logic [ADDR_W-1:0] main_dst;
  logic [DATA_W-1:0] main_data;
  logic [CTRL_W-1:0] skid_ctrl;
  logic [ADDR_W-1:0] skid_dst;
  logic [DATA_W-1:0] skid_data;
  logic              in_fire;
  logic              out_fire;
  logic [1:0]        stall_inc;
  logic [1:0]        kill_inc;

  // Without a skid entry, ready must look through to downstream combinationally.
  assign in_ready  = (SKID != 0) ? ready_q : (rst && (!out_valid || out_ready));
  assign out_valid = (occ != EMPTY);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // Zeroed dst when empty so forwarding logic sees no hazard.
  assign out_ctrl  = out_valid ? main_ctrl : '0;
  assign out_dst   = out_valid ? main_dst  : '0;
  assign out_data  = main_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      occ       <= EMPTY;
      ready_q   <= 1'b0;
      main_ctrl <= '0;
      main_dst  <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_dst  <= '0;
      skid_data <= '0;
    end else if (flush) begin
      occ     <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      ready_q <= 1'b1;
      case (occ)
        EMPTY: begin
          if (in_fire) begin
            occ       <= ONE;
            main_ctrl <= in_ctrl;
            main_dst  <= in_dst;
            main_data <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_ctrl <= in_ctrl;
            main_dst  <= in_dst;
            main_data <= in_data;
          end else if (in_fire && (SKID != 0)) begin
            occ       <= TWO;
            ready_q   <= 1'b0;
            skid_ctrl <= in_ctrl;
            skid_dst  <= in_dst;
            skid_data <= in_data;
          end else if (out_fire) begin
            occ <= EMPTY;
          end
        end
        TWO: begin
          // Skid entry always drains through main so ordering is preserved.
          if (out_fire) begin
            occ       <= ONE;
            main_ctrl <= skid_ctrl;
            main_dst  <= skid_dst;
            main_data <= skid_data;
          end else begin
            ready_q <= 1'b0;
          end
        end
        default: begin
          occ <= EMPTY;
        end
      endcase
    end
  end

  assign stall_inc = {1'b0, out_valid && !out_ready};
  assign kill_inc  = flush ? occ_count(occ) : 2'd0;

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (kill_inc),
    .cnt (kill_cnt)
  );

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised inter-stage pipeline register with a valid/ready handshake, an optional skid entry, synchronous flush with bubble insertion, and saturating stall/flush counters. It is the next-generation replacement for the fixed execute→memory latch: it sits between any two pipeline stages, such as X→M or M→W. It carries a control word, a destination register address and a data payload. A downstream stall backpressures the upstream stage without a combinational ready path, provided the skid entry is enabled.

## Interface
- DATA_W, 64, payload width (ALU result plus store value, packed by the instantiating stage)
- ADDR_W, 5, destination register address width
- CTRL_W, 8, downstream control word width
- SKID, 1, 1 = two-entry skid (registered in_ready); 0 = single entry (combinational in_ready)
- CNT_W, 16, performance counter width
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control word
- in_dst  in  ADDR_W  destination register address
- in_data  in  DATA_W  payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head
- out_ctrl  out  CTRL_W  head control (zero when !out_valid)
- out_dst  out  ADDR_W  head destination (zero when !out_valid)
- out_data  out  DATA_W  head payload (undefined when !out_valid)
- cnt_clr  in  1  synchronous clear of both counters
- stall_cnt  out  CNT_W  cycles with out_valid && !out_ready, saturating
- kill_cnt  out  CNT_W  valid entries discarded by flush, saturating

## Operation
- Handshake definitions: in_fire = in_valid && in_ready; out_fire = out_valid && out_ready.
- Upstream must hold its in_* values stable while in_valid && !in_ready.
- Occupancy states are EMPTY, ONE (main entry full) and TWO (main and skid full; reachable only when SKID=1).
- in_ready: with SKID=1, in_ready = (state != TWO), registered. With SKID=0, in_ready = !out_valid || out_ready. Forced 0 while rst is asserted.
- EMPTY: in_fire → ONE, main ← input.
- ONE:
  - in_fire && out_fire → ONE, main ← input.
  - in_fire && !out_fire → TWO, skid ← input.
  - out_fire only → EMPTY.
- TWO: out_fire → ONE, main ← skid. Order is preserved; the skid entry is never presented ahead of main.
- flush has highest priority. Next state is EMPTY, and out_ctrl/out_dst are zeroed, so dst 0 reads as no hazard to forwarding logic. An in_fire in the flush cycle is discarded.
- kill_cnt adds the number of valid entries held at the flush edge: 0, 1 or 2.
- Counters saturate at all-ones. If cnt_clr coincides with an increment, the clear wins.
- Width rule: counter increments are zero-extended, and the 2-entry kill add saturates rather than wrapping.

## Timing
- Latency: 1 cycle from in_fire into EMPTY to out_valid.
- Throughput: 1 entry/cycle while out_ready stays high.
- With SKID=1, in_ready deasserts the cycle after the skid entry fills. It reasserts the cycle after an out_fire from TWO.
- Reset values: state EMPTY, out_valid 0, out_ctrl 0, out_dst 0, out_data 0, both counters 0, in_ready 0 during reset.
  - With SKID=1, in_ready becomes 1 on the first edge after release.
- Reset mid-operation drops all entries immediately (asynchronous). Dropped entries are not counted in kill_cnt.
- flush with out_ready high in the same cycle: the head is killed, not delivered, and is counted in kill_cnt.

## Structure
- Package definitions adds `pipe_occ_e` (EMPTY/ONE/TWO).
- Per-stage bundle typedefs stay in definitions; instantiating stages pack them into in_ctrl/in_data.
- Sub-module: `sat_counter` (parameter CNT_W; inputs clr, inc amount 0–2; saturating), instantiated twice.

## Test plan
- Streaming, SKID=1, out_ready=1: 4 back-to-back entries with dst 1..4 → out_dst 1,2,3,4 on consecutive cycles, each 1 cycle after input. in_ready stays 1; stall_cnt = 0.
- Backpressure: out_ready=0 for 3 cycles while feeding dst 7, 8, 9 → state reaches TWO and in_ready drops after dst 8. dst 9 is held upstream. On release, outputs are 7, 8, 9 in order; stall_cnt = 3.
- Flush in TWO with in_valid=1 → next cycle out_valid=0, out_ctrl=0, out_dst=0, kill_cnt = 2, and the concurrent input is never output.
- SKID=0 variant: out_ready=0 with head held → in_ready=0 in the same cycle. When out_ready=1 and in_valid=1, the head is replaced in one cycle.
- Async reset asserted mid-stream (no clock edge) → out_valid=0 and counters 0 immediately. in_ready=0 until release, then 1 on the first edge after release.
- Saturation, CNT_W=4: hold a stall for 20 cycles → stall_cnt = 15. Assert cnt_clr with a stall active → 0 next cycle.
